// File: rtl/bc_pkg.sv
// Shared types and defaults for the bit-serial transmit path.
// State enum plus the default word width and bit period.
package bc_pkg;

  localparam int BC_DATA_W       = 16;
  localparam int BC_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/bc_bit_timer.sv
// Bit-period timer: pulses o_bit_tick on the last cycle of every CLKS_PER_BIT window.
// No latency beyond the count itself; i_clr restarts the window so each state begins a fresh bit.
module bc_bit_timer
  import bc_pkg::*;
#(
  parameter int CLKS_PER_BIT = BC_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bc_tx_serializer.sv
// Pops words from a FIFO and sends them as start / MSB-first data / even parity / stop frames.
// Two idle-high cycles (FETCH, LOAD) precede each frame; enable only gates the start of the next frame.
module bc_tx_serializer
  import bc_pkg::*;
#(
  parameter int DATA_W       = BC_DATA_W,
  parameter int CLKS_PER_BIT = BC_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_nxt;
  logic              r_parity;
  logic              r_ser_out;
  logic              w_ser_nxt;
  logic              w_bit_tick;
  logic              w_state_chg;
  logic              w_last_bit;
  logic              w_start_ok;

  assign w_start_ok  = enable && !fifo_empty;
  assign w_last_bit  = (r_bit_idx == IDX_W'(DATA_W - 1));
  assign w_state_chg = (w_state_nxt != r_state);

  bc_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_state_chg),
    .o_bit_tick(w_bit_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    fifo_rd_en    = 1'b0;
    frame_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = FETCH;
      end
      FETCH: begin
        // Never pop an empty FIFO; fall back to IDLE if the word disappeared.
        fifo_rd_en  = !fifo_empty;
        w_state_nxt = fifo_empty ? IDLE : LOAD;
      end
      LOAD: begin
        w_shift_nxt = fifo_dout;
        w_state_nxt = START;
      end
      START: begin
        if (w_bit_tick) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_tick) begin
          if (w_last_bit) begin
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_shift_nxt   = r_shift << 1;
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_tick) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_tick) begin
          frame_done  = 1'b1;
          w_state_nxt = w_start_ok ? FETCH : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state) w_bit_idx_nxt = '0;
  end

  // Line level is derived from the next state so ser_out lines up with the state it belongs to.
  always_comb begin
    w_ser_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_ser_nxt = 1'b0;
      DATA:    w_ser_nxt = w_shift_nxt[DATA_W-1];
      PARITY:  w_ser_nxt = r_parity;
      default: w_ser_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_ser_out <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_ser_out <= w_ser_nxt;
      if (r_state == LOAD) r_parity <= ^fifo_dout;
    end
  end

  assign ser_out = r_ser_out;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_bc_tx_serializer.sv
// Randomized bench for bc_tx_serializer: a FIFO model feeds words, a line monitor rebuilds
// each frame and compares it with the frame expected for the next word popped.
module tb_bc_tx_serializer;

  localparam int DW  = 16;
  localparam int CPB = 4;
  localparam int PEN = 1;
  localparam int FL  = (DW + 2 + PEN) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          ser_out;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  bc_tx_serializer #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (PEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .ser_out   (ser_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sent_q[$];
  int            gap_q[$];
  int            n_pass = 0;
  int            n_chk = 0;
  int            frames = 0;
  int            pops = 0;
  int            gap = 0;
  int            cap = 0;
  int            done_pos = -1;
  int            done_cnt = 0;
  int            stray_done = 0;
  int            busy_err = 0;
  bit            in_frame = 1'b0;
  bit            prev_rd = 1'b0;
  logic [FL-1:0] cap_bits = '1;
  logic [FL-1:0] last_frame = '1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Line image of one frame: start 0, data MSB first, even parity, stop 1, each bit CPB cycles.
  function automatic logic [FL-1:0] exp_frame(input logic [DW-1:0] w);
    logic [FL-1:0] f;
    logic          b;
    int            k;
    f = '1;
    k = 0;
    for (int i = 0; i < DW + 2 + PEN; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= DW) b = w[DW-i];
      else if (PEN != 0 && i == DW + 1) b = ^w;
      else b = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        f[k] = b;
        k++;
      end
    end
    return f;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    logic [DW-1:0] w;
    @(negedge clk);
    if (prev_rd && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      fifo_dout = w;
      sent_q.push_back(w);
      pops++;
    end else begin
      fifo_dout = DW'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_rd_en) check("rd_while_empty", 128'(fifo_empty), 128'(0));
    prev_rd = fifo_rd_en && !rst;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && ser_out == 1'b0) begin
        in_frame = 1'b1;
        cap = 0;
        done_cnt = 0;
        done_pos = -1;
        gap_q.push_back(gap);
      end
      if (in_frame) begin
        cap_bits[cap] = ser_out;
        if (frame_done) begin
          done_cnt++;
          done_pos = cap;
        end
        if (!busy) busy_err++;
        cap++;
        if (cap == FL) begin
          in_frame = 1'b0;
          gap = 0;
          frames++;
          last_frame = cap_bits;
          if (sent_q.size() == 0) check("frame_unexpected", 128'(1), 128'(0));
          else check("frame_bits", 128'(cap_bits), 128'(exp_frame(sent_q.pop_front())));
          check("frame_done_pos", 128'(done_pos), 128'(FL - 1));
          check("frame_done_cnt", 128'(done_cnt), 128'(1));
        end
      end else begin
        gap++;
        if (frame_done) stray_done++;
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 128'(frames), 128'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int f0;
    int bad;
    int ones;
    int n;

    repeat (3) cycle();
    check("rst_ser_out", 128'(ser_out), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rd_en", 128'(fifo_rd_en), 128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
    rst = 1'b0;
    enable = 1'b1;

    bad = 0;
    repeat (100) begin
      cycle();
      if (ser_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
    end
    check("idle_empty_fifo", 128'(bad), 128'(0));

    base = pops;
    push(16'h000A);
    wait_frames(frames + 1, 200, "frame_000a");
    check("pops_000a", 128'(pops - base), 128'(1));

    push(16'h0001);
    wait_frames(frames + 1, 200, "frame_0001");
    check("parity_0001", 128'(last_frame[(DW+1)*CPB]), 128'(1));

    push(16'hFFFF);
    wait_frames(frames + 1, 200, "frame_ffff");
    ones = 0;
    for (int i = CPB; i < (DW + 1) * CPB; i++) if (last_frame[i]) ones++;
    check("ffff_data_ones", 128'(ones), 128'(DW * CPB));
    check("parity_ffff", 128'(last_frame[(DW+1)*CPB]), 128'(0));

    repeat (10) cycle();
    base = pops;
    f0 = frames;
    push(16'h000A);
    push(16'h000B);
    push(16'h000C);
    wait_frames(f0 + 3, 400, "frames_b2b");
    check("pops_b2b", 128'(pops - base), 128'(3));
    check("gap_b2b_1", 128'(gap_q[gap_q.size()-2]), 128'(2));
    check("gap_b2b_2", 128'(gap_q[gap_q.size()-1]), 128'(2));

    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      push(DW'($urandom));
      repeat ($urandom_range(0, 90)) cycle();
    end
    wait_frames(f0 + 10, 1200, "frames_random");

    repeat (5) cycle();
    base = pops;
    f0 = frames;
    for (int i = 0; i < 3; i++) push(DW'($urandom));
    n = 0;
    while (!(in_frame && cap > (DW + 1) * CPB) && n < 300) begin
      cycle();
      n++;
    end
    check("reach_parity", 128'(in_frame && cap > (DW + 1) * CPB), 128'(1));
    enable = 1'b0;
    wait_frames(f0 + 1, 100, "frame_after_drop");
    repeat (100) cycle();
    check("pops_enable_low", 128'(pops - base), 128'(1));
    check("frames_enable_low", 128'(frames), 128'(f0 + 1));
    check("fifo_left", 128'(fifo_q.size()), 128'(2));
    check("idle_after_drop", 128'(busy), 128'(0));
    enable = 1'b1;
    wait_frames(f0 + 3, 300, "frames_resume");
    check("pops_resume", 128'(pops - base), 128'(3));

    repeat (5) cycle();
    base = pops;
    f0 = frames;
    push(DW'($urandom));
    n = 0;
    while (!(in_frame && cap == 8 * CPB + 2) && n < 300) begin
      cycle();
      n++;
    end
    check("reach_bit7", 128'(in_frame && cap == 8 * CPB + 2), 128'(1));
    rst = 1'b1;
    #1;
    check("midrst_ser_out", 128'(ser_out), 128'(1));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_frame_done", 128'(frame_done), 128'(0));
    cycle();
    cycle();
    sent_q.delete();
    prev_rd = 1'b0;
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      cycle();
      if (ser_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", 128'(bad), 128'(0));
    check("post_rst_frames", 128'(frames), 128'(f0));
    check("post_rst_pops", 128'(pops - base), 128'(1));

    check("stray_frame_done", 128'(stray_done), 128'(0));
    check("busy_in_frame", 128'(busy_err), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
